conv_acc_relu_sat: RTL

- Sits directly downstream of the conv1 14s x 9s -> 24-bit signed multiplier and consumes its product stream.
- Accumulates N_TAPS products per output pixel and seeds each window with a per-channel bias.
- Then rounds and rescales the sum, applies optional ReLU and saturates to the 14-bit activation format.
- The result goes to the next layer / line buffer over a valid/ready handshake.

---
 rtl/conv_acc_relu_sat.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/conv_acc_relu_sat.sv
// Accumulates N_TAPS signed products per output pixel on top of a per-channel bias,
// then rounds, rescales, optionally applies ReLU and saturates to the activation format.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_ACC  | accepting products, accumulating the current window
//   ST_HOLD | result registered, waiting for downstream to take it
module conv_acc_relu_sat #(
    parameter int PROD_W  = 24,
    parameter int ACC_W   = 32,
    parameter int N_TAPS  = 9,
    parameter int BIAS_W  = 14,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 14,
    parameter int RELU_EN = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     clear,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sat
);
    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int OMAX  = 2**(OUT_W-1) - 1;
    localparam int OMIN  = -(2**(OUT_W-1));
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(OMAX);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(OMIN);
    localparam logic signed [ACC_W:0] RND =
        {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]   bias_ext, prod_ext, acc_base, sum_full;
    logic signed [ACC_W:0]     rnd_sum, shifted, post_r;
    logic signed [OUT_W-1:0]   post_data;
    logic                      post_sat;
    logic                      last_tap;

    // The first tap of a window starts from the bias instead of the stale accumulator.
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} <<< SHIFT;
    assign prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    assign acc_base = (tap_cnt_q == '0) ? bias_ext : acc_q;
    assign sum_full = acc_base + prod_ext;
    assign last_tap = (tap_cnt_q == CNT_W'(N_TAPS-1));

    assign rnd_sum  = {sum_full[ACC_W-1], sum_full} + RND;
    assign shifted  = rnd_sum >>> SHIFT;

    always_comb begin
        post_r    = shifted;
        post_sat  = 1'b0;
        post_data = shifted[OUT_W-1:0];
        if (RELU_EN != 0 && shifted[ACC_W]) begin
            post_r = '0;
        end
        if (post_r > OUT_MAX) begin
            post_data = OUT_MAX[OUT_W-1:0];
            post_sat  = 1'b1;
        end else if (post_r < OUT_MIN) begin
            post_data = OUT_MIN[OUT_W-1:0];
            post_sat  = 1'b1;
        end else begin
            post_data = post_r[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            tap_cnt_d   = '0;
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (prod_valid) begin
                        acc_d = sum_full;
                        if (last_tap) begin
                            tap_cnt_d   = '0;
                            out_data_d  = post_data;
                            out_sat_d   = post_sat;
                            out_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            tap_cnt_d = tap_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_ACC;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready depends only on registered state, never on the handshake inputs.
    assign prod_ready = (state_q == ST_ACC);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
endmodule
